// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: serially loads a frame of pixel intensities and emits, over a fixed
// 2^INT_W-step window, a spike train per channel whose count equals its intensity.
module spike_rate_encoder #(
    parameter int NUM_CH = 8,
    parameter int INT_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              pix_valid_i,
    input  logic [INT_W-1:0]  pix_data_i,
    output logic              pix_ready_o,
    input  logic              start_i,
    output logic              busy_o,
    output logic [NUM_CH-1:0] spike_o,
    output logic              spike_valid_o,
    output logic              done_o
);
    localparam int WINDOW = 1 << INT_W;
    localparam int PTR_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {LOAD, ARMED, RUN} state_t;

    state_t                          state, state_nxt;
    logic [PTR_W-1:0]                ptr;
    logic [NUM_CH-1:0][INT_W-1:0]    intensity;
    logic [NUM_CH-1:0][INT_W-1:0]    acc;
    logic [INT_W-1:0]                step;
    logic                            last_pix, last_step;

    assign last_pix    = ptr == PTR_W'(NUM_CH - 1);
    assign last_step   = step == INT_W'(WINDOW - 1);
    assign pix_ready_o = state == LOAD;
    assign busy_o      = state == RUN;

    always_comb begin
        state_nxt = state;
        if (clear_i)
            state_nxt = LOAD;
        else
            case (state)
                LOAD:    state_nxt = pix_valid_i && last_pix ? ARMED : LOAD;
                ARMED:   state_nxt = start_i ? RUN : ARMED;
                RUN:     state_nxt = last_step ? ARMED : RUN;
                default: state_nxt = LOAD;
            endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni)
            state <= LOAD;
        else
            state <= state_nxt;

    // The carry out of each phase accumulator is the spike: it fires exactly I times per wrap of 2^INT_W.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr           <= '0;
            intensity     <= '0;
            acc           <= '0;
            step          <= '0;
            spike_o       <= '0;
            spike_valid_o <= 1'b0;
            done_o        <= 1'b0;
        end else if (clear_i) begin
            ptr           <= '0;
            spike_o       <= '0;
            spike_valid_o <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            spike_o       <= '0;
            spike_valid_o <= 1'b0;
            done_o        <= 1'b0;
            if (state == LOAD && pix_valid_i) begin
                intensity[ptr] <= pix_data_i;
                ptr            <= last_pix ? '0 : ptr + 1'b1;
            end
            if (state == ARMED && start_i) begin
                acc  <= '0;
                step <= '0;
            end
            if (state == RUN) begin
                for (int c = 0; c < NUM_CH; c++)
                    {spike_o[c], acc[c]} <= {1'b0, acc[c]} + {1'b0, intensity[c]};
                spike_valid_o <= 1'b1;
                step          <= step + 1'b1;
                done_o        <= last_step;
            end
        end
    end
endmodule

// File: doc/spike_rate_encoder.md
# spike_rate_encoder

Input-side counterpart to the spiking network's readout path. It converts a frame of multi-bit pixel intensities into per-timestep binary spike vectors: the network consumes those vectors, and spike_counter/max_spike decode them downstream. Pixels are loaded serially over a valid/ready handshake. On start, the block runs a fixed window in which each channel emits exactly as many spikes as its intensity, spread deterministically by a per-channel phase accumulator.

## Interface
Parameters:
- NUM_CH, 8: number of input channels (spike lanes).
- INT_W, 4: intensity width. The window length is fixed at WINDOW = 2^INT_W timesteps (16 by default).

Ports:
- clk_i, input, 1: clock; all state updates on the rising edge.
- rst_ni, input, 1: reset. One clock; reset is asynchronous and active-low.
- clear_i, input, 1: synchronous soft clear. Returns to LOAD, resets the load pointer, zeroes the spike outputs. Has priority over all other inputs.
- pix_valid_i, input, 1: pixel data valid.
- pix_data_i, input, INT_W: intensity for the channel at the current load pointer.
- pix_ready_o, output, 1: high exactly when state == LOAD.
- start_i, input, 1: begin a run. Honoured only in ARMED.
- busy_o, output, 1: high exactly when state == RUN.
- spike_o, output, NUM_CH: registered spike vector for the current timestep.
- spike_valid_o, output, 1: high for each cycle where spike_o carries timestep 1..WINDOW.
- done_o, output, 1: one-cycle pulse, coincident with timestep WINDOW.

## Operation
- State machine states: LOAD, ARMED, RUN.
- LOAD
  - A transfer occurs when pix_valid_i && pix_ready_o.
  - Each transfer writes intensity[ptr] = pix_data_i, then ptr increments.
  - Transfer NUM_CH-1 moves the state to ARMED and resets ptr to 0.
- ARMED
  - pix_ready_o = 0; pix_valid_i is ignored.
  - start_i = 1 moves the state to RUN, zeroes every acc[c] (INT_W bits) and sets step = 0.
- RUN, on every cycle:
  - For each c: {carry, acc[c]} = acc[c] + intensity[c] (INT_W+1 bit sum).
  - spike_o[c] <= carry; spike_valid_o <= 1; step++.
  - On the update where step == WINDOW-1, done_o <= 1 and the state returns to ARMED.
  - Intensities are retained, so a further start_i re-runs the same frame.
- Arithmetic guarantee: over one window, channel c emits exactly intensity[c] spikes. Timestep t (1-based) spikes iff floor(t·I/2^INT_W) > floor((t-1)·I/2^INT_W).
  - I = 0 never spikes.
  - I = 2^INT_W-1 spikes every step except t = 1.
- Outside RUN updates, spike_o, spike_valid_o and done_o are registered to 0.
- clear_i in any state, including mid-RUN:
  - Next cycle: LOAD, ptr = 0, spike_o = 0, spike_valid_o = 0, done_o = 0, busy_o = 0.
  - Stored intensities become don't-care; a full reload is required.
- start_i in LOAD or RUN is ignored; there is no queuing.
- Loading a new frame requires clear_i first.

## Timing
- Reset values:
  - state = LOAD; pix_ready_o = 1 during and after reset.
  - busy_o = 0, spike_o = 0, spike_valid_o = 0, done_o = 0.
  - ptr = 0, all acc = 0, all intensity = 0.
- Loading: one pixel per cycle at full throughput, so NUM_CH consecutive valid cycles fill the frame.
  - pix_ready_o drops in the cycle after the last transfer.
- Run timing, with start_i sampled high at edge k:
  - busy_o is high in cycles k+1 .. k+WINDOW.
  - spike_o for timestep t appears after edge k+t (t = 1..WINDOW).
  - done_o and spike_valid_o for t = WINDOW appear after edge k+WINDOW.
  - After edge k+WINDOW+1: outputs are 0 and state is ARMED.
- Back-to-back runs:
  - busy_o falls to 0 after edge k+WINDOW.
  - start_i held high from cycle k+WINDOW onward is sampled at edge k+WINDOW+1, starting the next run. That run's first timestep appears after edge k+WINDOW+2.
  - This leaves one cycle with spike_valid_o = 0 between windows.
- Reset asserted mid-operation: all outputs take their reset values immediately (asynchronous), independent of the clock.

## Test plan
- Reset then load, intensities ch0..7 = 0,1,2,4,8,15,3,5, then start → per-window spike counts exactly 0,1,2,4,8,15,3,5. ch4 (I=8) spikes at t = 2,4,…,16. ch1 (I=1) spikes only at t = 16. done_o is asserted only at t = 16.
- Timing check → with start at edge k: busy_o high for exactly 16 cycles; spike_valid_o high for exactly 16 cycles; pix_ready_o = 0 from load completion until clear_i.
- Load with random pix_valid_i gaps, plus pix_valid_i held high in ARMED and RUN → exactly 8 writes occur. Extra data is ignored and does not alter the spike counts.
- Re-run: after done, start_i again without reload → identical spike pattern. start_i pulsed during RUN → no effect; window length is still 16.
- clear_i at t = 7 of RUN → next cycle spike_o = 0, busy_o = 0, pix_ready_o = 1. Reloading 8 pixels of value 15 then produces 15 spikes per channel.
- rst_ni asserted asynchronously mid-load (ptr = 3) and mid-run → outputs are immediately at reset values. After release, a full 8-pixel load is required before start_i has any effect.
